// File: rtl/nco_ctrl_pkg.sv
// Shared state type and default widths for the NCO sweep controller.
package nco_ctrl_pkg;
    localparam int NCO_FW = 28;
    localparam int NCO_SW = 10;
    localparam int NCO_DW = 16;
    // Tuning word for frequency f at clock fclk is NCO_FULL_SCALE*f/fclk.
    localparam longint unsigned NCO_FULL_SCALE = 64'd1 << NCO_FW;

    typedef enum logic [1:0] {IDLE, DWELL, FIN} sweep_state_t;
endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter with terminal-count (zero) flag; also used for burst gating.
module nco_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency / chirp sequencer driving an NCO tuning word.
// Build macro NCO_SWEEP_TRIANGLE_EN adds cfg_tri for up-then-down sweeps.
//   state | meaning
//   IDLE  | waiting for start; freq_out holds its last value
//   DWELL | holding the current word for dwell+1 cycles, then stepping
//   FIN   | one-cycle done pulse, then back to IDLE
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int FW = NCO_FW,
    parameter int SW = NCO_SW,
    parameter int DW = NCO_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] cfg_start,
    input  logic [FW-1:0] cfg_step,
    input  logic [SW-1:0] cfg_nsteps,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_loop,
`ifdef NCO_SWEEP_TRIANGLE_EN
    input  logic          cfg_tri,
`endif
    output logic [FW-1:0] freq_out,
    output logic          phase_clr,
    output logic          step_tick,
    output logic          busy,
    output logic          done
);
    sweep_state_t  state, state_nxt;
    logic [FW-1:0] freq_nxt, sh_start, sh_step;
    logic [SW-1:0] sh_nsteps, step_idx, idx_nxt;
    logic [DW-1:0] sh_dwell, tmr_val;
    logic          sh_loop, latch, tmr_load, tmr_dec, tmr_zero, seq_end;
    logic          busy_nxt, phase_clr_nxt, step_tick_nxt, done_nxt;
`ifdef NCO_SWEEP_TRIANGLE_EN
    logic          sh_tri, dir, dir_nxt;
`endif

    assign tmr_val = latch ? cfg_dwell : sh_dwell;

    nco_dwell_timer #(.W(DW)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt     = state;
        freq_nxt      = freq_out;
        idx_nxt       = step_idx;
        busy_nxt      = busy;
        phase_clr_nxt = 1'b0;
        step_tick_nxt = 1'b0;
        done_nxt      = 1'b0;
        latch         = 1'b0;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;
        seq_end       = 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
        dir_nxt       = dir;
`endif
        if (abort) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    latch         = 1'b1;
                    tmr_load      = 1'b1;
                    freq_nxt      = cfg_start;
                    idx_nxt       = '0;
                    phase_clr_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                    state_nxt     = DWELL;
`ifdef NCO_SWEEP_TRIANGLE_EN
                    dir_nxt       = 1'b0;
`endif
                end
                DWELL: if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    tmr_load      = 1'b1;
                    step_tick_nxt = 1'b1;
`ifdef NCO_SWEEP_TRIANGLE_EN
                    // Down leg counts step_idx back to zero.
                    if (dir) begin
                        if (step_idx != '0) begin
                            freq_nxt = freq_out - sh_step;
                            idx_nxt  = step_idx - SW'(1);
                        end else begin
                            seq_end = 1'b1;
                        end
                    end else
`endif
                    if (step_idx != sh_nsteps) begin
                        freq_nxt = freq_out + sh_step;
                        idx_nxt  = step_idx + SW'(1);
                    end
`ifdef NCO_SWEEP_TRIANGLE_EN
                    else if (sh_tri && sh_nsteps != '0) begin
                        dir_nxt  = 1'b1;
                        freq_nxt = freq_out - sh_step;
                        idx_nxt  = step_idx - SW'(1);
                    end
`endif
                    else begin
                        seq_end = 1'b1;
                    end

                    if (seq_end) begin
                        if (sh_loop) begin
                            freq_nxt = sh_start;
                            idx_nxt  = '0;
`ifdef NCO_SWEEP_TRIANGLE_EN
                            dir_nxt  = 1'b0;
`endif
                        end else begin
                            step_tick_nxt = 1'b0;
                            busy_nxt      = 1'b0;
                            done_nxt      = 1'b1;
                            state_nxt     = FIN;
                        end
                    end
                end
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            freq_out  <= '0;
            step_idx  <= '0;
            busy      <= 1'b0;
            phase_clr <= 1'b0;
            step_tick <= 1'b0;
            done      <= 1'b0;
            sh_start  <= '0;
            sh_step   <= '0;
            sh_nsteps <= '0;
            sh_dwell  <= '0;
            sh_loop   <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
            sh_tri    <= 1'b0;
            dir       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            freq_out  <= freq_nxt;
            step_idx  <= idx_nxt;
            busy      <= busy_nxt;
            phase_clr <= phase_clr_nxt;
            step_tick <= step_tick_nxt;
            done      <= done_nxt;
`ifdef NCO_SWEEP_TRIANGLE_EN
            dir       <= dir_nxt;
`endif
            if (latch) begin
                sh_start  <= cfg_start;
                sh_step   <= cfg_step;
                sh_nsteps <= cfg_nsteps;
                sh_dwell  <= cfg_dwell;
                sh_loop   <= cfg_loop;
`ifdef NCO_SWEEP_TRIANGLE_EN
                sh_tri    <= cfg_tri;
`endif
            end
        end
    end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed cases plus random sweeps vs a word-list model.
module tb_nco_sweep_ctrl;
    import nco_ctrl_pkg::*;

    localparam int FW = NCO_FW;
    localparam int SW = NCO_SW;
    localparam int DW = NCO_DW;

    logic          clk = 1'b0;
    logic          rst, start, abort, cfg_loop;
    logic [FW-1:0] cfg_start, cfg_step;
    logic [SW-1:0] cfg_nsteps;
    logic [DW-1:0] cfg_dwell;
`ifdef NCO_SWEEP_TRIANGLE_EN
    logic          cfg_tri;
`endif
    logic [FW-1:0] freq_out;
    logic          phase_clr, step_tick, busy, done;

    int     n_checks = 0;
    int     n_errors = 0;
    longint mdl_freq = 0;
    longint e_freq [256];
    bit     e_pc   [256];
    bit     e_tick [256];
    bit     e_busy [256];
    bit     e_done [256];

    nco_sweep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_start  (cfg_start),
        .cfg_step   (cfg_step),
        .cfg_nsteps (cfg_nsteps),
        .cfg_dwell  (cfg_dwell),
        .cfg_loop   (cfg_loop),
`ifdef NCO_SWEEP_TRIANGLE_EN
        .cfg_tri    (cfg_tri),
`endif
        .freq_out   (freq_out),
        .phase_clr  (phase_clr),
        .step_tick  (step_tick),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Expected trace for cycles 1..n after start: the sweep is a list of words, each held dw+1 cycles.
    task automatic build_model(input longint st, input longint sp, input int ns, input int dw,
                               input bit lp, input bit tr, input int n, input int ab, input int rs);
        longint wq[$];
        int     hold, len, m;
        wq = {};
        for (int i = 0; i <= ns; i++) wq.push_back((st + i * sp) % NCO_FULL_SCALE);
        if (tr && ns > 0)
            for (int i = ns - 1; i >= 0; i--) wq.push_back((st + i * sp) % NCO_FULL_SCALE);
        hold = dw + 1;
        len  = wq.size() * hold;
        for (int k = 1; k <= n; k++) begin
            m = k - 1;
            e_pc[k] = 0; e_tick[k] = 0; e_busy[k] = 0; e_done[k] = 0;
            if (rs > 0 && k > rs) begin
                e_freq[k] = 0;
            end else if (ab > 0 && k > ab) begin
                e_freq[k] = e_freq[ab];
            end else if (lp || m < len) begin
                e_freq[k] = wq[(m % len) / hold];
                e_pc[k]   = (m == 0);
                e_tick[k] = (m != 0) && (m % hold == 0);
                e_busy[k] = 1;
            end else begin
                e_freq[k] = wq[wq.size() - 1];
                e_done[k] = (m == len);
            end
        end
    endtask

    task automatic noise_cfg();
        cfg_start  = FW'($urandom);
        cfg_step   = FW'($urandom);
        cfg_nsteps = SW'($urandom);
        cfg_dwell  = DW'($urandom);
        cfg_loop   = 1'($urandom);
`ifdef NCO_SWEEP_TRIANGLE_EN
        cfg_tri    = 1'($urandom);
`endif
    endtask

    // Starts a sweep, then checks n cycles; ab/rs/bs are the cycles to assert abort/rst/stray start (0 = never).
    task automatic run_sweep(input string name, input longint st, input longint sp, input int ns, input int dw,
                             input bit lp, input bit tr, input int n, input int ab, input int rs, input int bs);
        build_model(st, sp, ns, dw, lp, tr, n, ab, rs);
        @(posedge clk); #1;
        rst = 0; abort = 0; start = 1;
        cfg_start = FW'(st); cfg_step = FW'(sp); cfg_nsteps = SW'(ns); cfg_dwell = DW'(dw); cfg_loop = lp;
`ifdef NCO_SWEEP_TRIANGLE_EN
        cfg_tri = tr;
`endif
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            start = (k == bs);
            abort = (k == ab);
            rst   = (k == rs);
            noise_cfg();
            @(negedge clk);
            chk($sformatf("%s c%0d freq_out", name, k), 64'(freq_out), e_freq[k]);
            chk($sformatf("%s c%0d phase_clr", name, k), 64'(phase_clr), 64'(e_pc[k]));
            chk($sformatf("%s c%0d step_tick", name, k), 64'(step_tick), 64'(e_tick[k]));
            chk($sformatf("%s c%0d busy", name, k), 64'(busy), 64'(e_busy[k]));
            chk($sformatf("%s c%0d done", name, k), 64'(done), 64'(e_done[k]));
        end
        mdl_freq = e_freq[n];
    endtask

    initial begin
        int     ns, dw, n, ab, bs, len;
        bit     lp, tr;
        longint st, sp;

        rst = 1; start = 0; abort = 0;
        cfg_start = '0; cfg_step = '0; cfg_nsteps = '0; cfg_dwell = '0; cfg_loop = 0;
`ifdef NCO_SWEEP_TRIANGLE_EN
        cfg_tri = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset freq_out", 64'(freq_out), 0);
        chk("reset phase_clr", 64'(phase_clr), 0);
        chk("reset step_tick", 64'(step_tick), 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset done", 64'(done), 0);

        run_sweep("basic", 2684354, 2684354, 3, 2, 0, 0, 13, 0, 0, 0);
        run_sweep("back2back", 2684354, 2684354, 3, 2, 0, 0, 13, 0, 0, 0);
        run_sweep("wrap", 268435455, 2, 1, 0, 0, 0, 3, 0, 0, 0);
        run_sweep("negstep", 100, 268435455, 2, 0, 0, 0, 4, 0, 0, 0);
        run_sweep("negdwell", 100, 268435455, 2, 1, 0, 0, 7, 0, 0, 0);
        run_sweep("loop", 1000, 500, 1, 0, 1, 0, 10, 10, 0, 0);
        run_sweep("tone_loop", 77, 5, 0, 2, 1, 0, 10, 10, 0, 0);
        run_sweep("abort5", 2684354, 2684354, 3, 2, 0, 0, 9, 5, 0, 0);
        run_sweep("abort_fin", 50, 3, 1, 0, 0, 0, 4, 3, 0, 0);
        run_sweep("busy_start", 2684354, 2684354, 3, 2, 0, 0, 13, 0, 0, 3);
        run_sweep("fin_start", 9, 1, 1, 1, 0, 0, 5, 0, 0, 5);
        run_sweep("rst7", 2684354, 2684354, 3, 2, 0, 0, 9, 0, 7, 0);

        // start with abort in IDLE must not launch a sweep
        @(posedge clk); #1;
        rst = 0; start = 1; abort = 1; noise_cfg();
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            start = 0; abort = 0;
            @(negedge clk);
            chk($sformatf("start_abort c%0d busy", k), 64'(busy), 0);
            chk($sformatf("start_abort c%0d phase_clr", k), 64'(phase_clr), 0);
            chk($sformatf("start_abort c%0d freq_out", k), 64'(freq_out), mdl_freq);
        end

`ifdef NCO_SWEEP_TRIANGLE_EN
        run_sweep("tri", 0, 10, 2, 0, 0, 1, 6, 0, 0, 0);
        run_sweep("tri_loop", 0, 10, 2, 0, 1, 1, 12, 12, 0, 0);
`endif

        for (int r = 0; r < 30; r++) begin
            st = longint'($urandom) % NCO_FULL_SCALE;
            sp = longint'($urandom) % NCO_FULL_SCALE;
            ns = $urandom_range(0, 5);
            dw = $urandom_range(0, 3);
            lp = ($urandom_range(0, 3) == 0);
            tr = 0;
`ifdef NCO_SWEEP_TRIANGLE_EN
            tr = 1'($urandom);
`endif
            len = ((tr && ns > 0) ? 2 * ns + 1 : ns + 1) * (dw + 1);
            if (lp) begin
                n  = 15;
                ab = $urandom_range(1, n);
            end else begin
                n  = len + 1;
                ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            end
            bs = ($urandom_range(0, 1) == 1) ? $urandom_range(2, n) : 0;
            if (ab > 0 && bs > ab) bs = 0;
            run_sweep($sformatf("rnd%0d", r), st, sp, ns, dw, lp, tr, n, ab, 0, bs);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer that drives the frequency tuning word of a phase-accumulator NCO. It produces stepped frequency sweeps and chirps: start word, signed step, step count and per-step dwell time, with optional looping. It sits between the register/config side and the NCO accumulator. Outputs are the tuning word and a one-cycle phase-clear strobe.

Parameters:
FW, 28, tuning-word width; must match the NCO accumulator width.
SW, 10, step-count width.
DW, 16, dwell-counter width.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle request to begin a sweep; ignored while busy
abort  in  1  terminate the sweep immediately; has priority over start
cfg_start  in  FW  first tuning word
cfg_step  in  FW  signed increment per step (two's complement)
cfg_nsteps  in  SW  number of increments after the first word
cfg_dwell  in  DW  hold time per word minus one, in cycles
cfg_loop  in  1  restart from cfg_start instead of finishing
freq_out  out  FW  tuning word to the NCO accumulator
phase_clr  out  1  one-cycle pulse; NCO zeroes its accumulator
step_tick  out  1  one-cycle pulse on every freq_out update after the first
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset: all outputs 0; state IDLE; shadow config registers 0.
- FSM states: IDLE, DWELL, FIN.
- IDLE, start=1 and abort=0:
  - latch all cfg_* into shadow registers (cfg_* are don't-care afterwards);
  - next cycle: freq_out=cfg_start, phase_clr=1, busy=1;
  - dwell_cnt=cfg_dwell, step_idx=0, go to DWELL.
- DWELL, dwell_cnt!=0: decrement dwell_cnt.
- DWELL, dwell_cnt==0 and step_idx!=nsteps:
  - freq_out += step, modulo 2^FW (wrap-around is silent and intended);
  - step_idx++, dwell_cnt reloads, step_tick=1.
- DWELL, dwell_cnt==0 and step_idx==nsteps:
  - loop=1: freq_out=start, step_idx=0, dwell_cnt reloads, step_tick=1, no phase_clr;
  - loop=0: go to FIN.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE.
- Timing:
  - each word is held dwell+1 cycles;
  - total busy cycles = (nsteps+1)*(dwell+1);
  - done occurs in the cycle after the last busy cycle.
- Edge cases:
  - nsteps=0: single tone; with loop=1, step_tick fires every dwell+1 cycles with the word unchanged.
  - dwell=0: word changes every cycle.
- abort in any state: next cycle IDLE, busy=0, no done, freq_out holds its value. abort in FIN suppresses nothing already emitted.
- start while busy (DWELL or FIN) is ignored. start in the cycle after done is accepted.
- freq_out is registered (no combinational path from inputs to any output). phase_clr, step_tick and done are registered pulses.
- rst asserted mid-sweep returns everything to reset values on the next edge.

Optional Feature:
NCO_SWEEP_TRIANGLE_EN.
- Defined:
  - adds input cfg_tri (1 bit), latched with the other config at start;
  - with cfg_tri=1, reaching step_idx==nsteps reverses direction: subtract step for nsteps more words back to start, then loop or FIN;
  - the turnaround word is not repeated;
  - busy duration = (2*nsteps+1)*(dwell+1).
- Not defined: cfg_tri port and direction register are absent; behaviour is sawtooth only.

Decomposition:
- Package nco_ctrl_pkg:
  - state enum type (IDLE, DWELL, FIN);
  - default width localparams (FW=28, SW=10, DW=16);
  - a helper constant NCO_FULL_SCALE = 2^FW, used by benches to compute words as NCO_FULL_SCALE*f/fclk.
- Sub-module nco_dwell_timer: loadable down-counter with a zero flag. Reused elsewhere for burst gating.

Test Plan:
- Basic sweep: start=2684354, step=2684354, nsteps=3, dwell=2, loop=0 -> freq_out steps 2684354 / 5368708 / 8053062 / 10737416, each held 3 cycles (cycles 1-12 after start); phase_clr in cycle 1; step_tick in cycles 4, 7, 10; busy in cycles 1-12; done in cycle 13.
- Wrap and negative step:
  - start=268435455, step=2, nsteps=1, dwell=0 -> 268435455 then 1;
  - start=100, step=268435455 (-1), nsteps=2 -> 100, 99, 98.
- Loop: start=1000, step=500, nsteps=1, dwell=0, loop=1 -> 1000, 1500, 1000, 1500 ...; step_tick every cycle from cycle 2; phase_clr only in cycle 1; done never asserted.
- Abort and collisions:
  - abort in cycle 5 of the basic sweep -> busy=0 from cycle 6, no done, freq_out stays 5368708;
  - start and abort asserted together in IDLE -> no sweep starts.
- Start while busy: a second start in cycle 3 with different cfg_* -> ignored, sequence identical to the basic sweep; rst in cycle 7 -> all outputs 0 in cycle 8.
- Triangle (with NCO_SWEEP_TRIANGLE_EN): start=0, step=10, nsteps=2, dwell=0, cfg_tri=1 -> freq_out 0, 10, 20, 10, 0; done in cycle 6.
